decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL have parameter NREG, default 32, register-file entries (power of 2, 2..32).
REQ-003 SHALL have parameter STALL_CNT_W, default 16, width of the stall counter.
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  processor clock
- reset  in  1  synchronous active-high reset
- valid_F  in  1  fetch slot holds an instruction
- PCmas4_F  in  XLEN  PC+4 of the fetched instruction
- instr_F  in  32  fetched instruction
- reg_write_signal  in  1  WB register write enable
- write_reg  in  5  WB destination
- write_data  in  XLEN  WB data
- dato_EXE, dato_MEM  in  XLEN  forwarding data from EXE and MEM
- dir_Rd_EXE, dir_Rd_MEM  in  5  destination registers in EXE and MEM
- RegWrite_EXE, RegWrite_MEM, MemRead_EXE, MemRead_MEM  in  1  producer control in EXE and MEM
- stall_F  out  1  hold PC and the fetch slot
- Select_PC  out  1  branch taken; redirect fetch
- dir_salto  out  XLEN  branch target
- valid_E, RegWrite_E, ALUSrc_E, MemRead_E, MemWrite_E, illegal_E  out  1  registered ID/EX control
- ALUControl_E  out  3  registered ALU operation
- Rs1_E, Rs2_E, imm_E  out  XLEN  registered operands and immediate
- rd_E  out  5  registered destination register
- stall_count  out  STALL_CNT_W  saturating count of stall cycles

Function
REQ-006 The IF/ID register SHALL hold {valid_D, PCmas4_D, instr_D}. When stall_F=0 it SHALL load {valid_F & ~Select_PC, PCmas4_F, instr_F}; when stall_F=1 it SHALL hold.
REQ-007 The register file SHALL have NREG x XLEN entries, 2 combinational read ports and 1 write port written at the clk edge.
- x0 SHALL read 0; writes to x0 SHALL be ignored.
- A read of the address being written in the same cycle SHALL return write_data.
REQ-008 Decode rules:
- Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011. Any other opcode is illegal.
- Immediates: I-imm for I and LOAD, S-imm for STORE, B-imm for BRANCH, all sign-extended to XLEN.
REQ-009 ALUControl encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
- funct3 map: 000 ADD (SUB when R and funct7[5]=1), 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
- funct3=011, and 101 with funct7[5]=1, are illegal.
- LOAD and STORE use ADD and are legal only with funct3=010.
- BRANCH uses SUB and is illegal with funct3 010 or 011.
REQ-010 Operand select for rs1 and rs2, in priority order:
- dato_EXE if RegWrite_EXE and dir_Rd_EXE==rs and rs!=0;
- else dato_MEM if RegWrite_MEM and dir_Rd_MEM==rs and rs!=0;
- else the register file.
The selected values SHALL feed both the branch comparator and the ID/EX register.
REQ-011 Source use: rs1 is used by R, I, LOAD, STORE and BRANCH; rs2 is used by R, STORE and BRANCH.
REQ-012 stall_F SHALL be 1 when valid_D and either condition holds:
- MemRead_EXE, dir_Rd_EXE!=0, and dir_Rd_EXE matches a used source; or
- the instruction is a BRANCH, MemRead_MEM, dir_Rd_MEM!=0, and dir_Rd_MEM matches a used source.
REQ-013 Branch resolution:
- Select_PC = valid_D & BRANCH & condition & ~stall_F.
- Conditions by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
- dir_salto = PCmas4_D - 4 + B-imm, modulo 2^XLEN.
REQ-014 The ID/EX register SHALL capture a bubble when stall_F=1, valid_D=0, or the instruction is illegal.
- Bubble: valid_E=0, all enables 0, all data fields 0.
- illegal_E SHALL be 1 for one cycle when an illegal instruction with valid_D=1 is dropped.
REQ-015 A branch SHALL enter ID/EX with valid_E=1 and RegWrite_E=MemRead_E=MemWrite_E=0.
REQ-016 ALUSrc_E SHALL be 1 for I, LOAD and STORE, and 0 otherwise.
REQ-017 stall_count SHALL increment on every cycle with stall_F=1 and saturate at all-ones.
REQ-018 Latency: one cycle from the IF/ID register to the ID/EX register. A load-use dependency costs one stall cycle; a branch depending on a load costs two.

Reset
REQ-019 With reset=1 at a clk edge, the following SHALL be cleared: valid_D, every ID/EX output, illegal_E, stall_count, and all register-file entries.
REQ-020 A reset asserted mid-stall SHALL take priority; the stall SHALL be discarded and stall_F SHALL be 0 in the cycle after reset.

Verification
REQ-021 addi x1,x0,5 then add x2,x1,x1 with x1 in EXE (dato_EXE=5) -> Rs1_E=Rs2_E=5, no stall.
REQ-022 lw x3 in EXE (MemRead_EXE=1, rd=3), ID holds add x4,x3,x0 -> stall_F=1 for 1 cycle, one bubble, stall_count +1.
REQ-023 beq x5,x6 with x5 in MEM via a load -> stall 1 cycle; once in WB, equal values -> Select_PC=1, dir_salto=PC+B-imm, next valid_D=0.
REQ-024 blt x7=-1 vs x8=1 -> taken; bltu on the same values -> not taken.
REQ-025 Opcode 1111111 -> illegal_E=1 for one cycle, valid_E=0; write to x0 then read -> 0; reset during a stall -> all outputs 0.

Source files
------------

// File: rtl/decode_pipe_if.sv
// Decode-stage bus: fetch slot, writeback, forwarding sources in; hazard,
// redirect and ID/EX register contents out.
interface decode_pipe_if #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
);
  logic                   valid_F;
  logic [XLEN-1:0]        PCmas4_F;
  logic [31:0]            instr_F;
  logic                   reg_write_signal;
  logic [4:0]             write_reg;
  logic [XLEN-1:0]        write_data;
  logic [XLEN-1:0]        dato_EXE;
  logic [XLEN-1:0]        dato_MEM;
  logic [4:0]             dir_Rd_EXE;
  logic [4:0]             dir_Rd_MEM;
  logic                   RegWrite_EXE;
  logic                   RegWrite_MEM;
  logic                   MemRead_EXE;
  logic                   MemRead_MEM;
  logic                   stall_F;
  logic                   Select_PC;
  logic [XLEN-1:0]        dir_salto;
  logic                   valid_E;
  logic                   RegWrite_E;
  logic                   ALUSrc_E;
  logic                   MemRead_E;
  logic                   MemWrite_E;
  logic                   illegal_E;
  logic [2:0]             ALUControl_E;
  logic [XLEN-1:0]        Rs1_E;
  logic [XLEN-1:0]        Rs2_E;
  logic [XLEN-1:0]        imm_E;
  logic [4:0]             rd_E;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output valid_F, PCmas4_F, instr_F, reg_write_signal, write_reg, write_data,
           dato_EXE, dato_MEM, dir_Rd_EXE, dir_Rd_MEM,
           RegWrite_EXE, RegWrite_MEM, MemRead_EXE, MemRead_MEM,
    input  stall_F, Select_PC, dir_salto, valid_E, RegWrite_E, ALUSrc_E,
           MemRead_E, MemWrite_E, illegal_E, ALUControl_E, Rs1_E, Rs2_E,
           imm_E, rd_E, stall_count
  );

  modport slave (
    input  valid_F, PCmas4_F, instr_F, reg_write_signal, write_reg, write_data,
           dato_EXE, dato_MEM, dir_Rd_EXE, dir_Rd_MEM,
           RegWrite_EXE, RegWrite_MEM, MemRead_EXE, MemRead_MEM,
    output stall_F, Select_PC, dir_salto, valid_E, RegWrite_E, ALUSrc_E,
           MemRead_E, MemWrite_E, illegal_E, ALUControl_E, Rs1_E, Rs2_E,
           imm_E, rd_E, stall_count
  );
endinterface

// File: rtl/decode_pipe.sv
// Decode stage: IF/ID register, register file, decoder, operand forwarding,
// load-use hazard stall, branch resolution and the ID/EX register.
module decode_pipe #(
  parameter int XLEN        = 32,
  parameter int NREG        = 32,
  parameter int STALL_CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  decode_pipe_if.slave bus
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [2:0] alu_of_funct3(input logic [2:0] f3);
    case (f3)
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  logic                   valid_D;
  logic [XLEN-1:0]        PCmas4_D;
  logic [31:0]            instr_D;
  logic [XLEN-1:0]        regs [NREG];

  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [4:0]             rs1_a, rs2_a, rd_a;
  logic                   f7b5;
  logic [XLEN-1:0]        imm_i, imm_s, imm_b, imm_sel;
  logic                   is_r, is_i, is_load, is_store, is_branch, legal;
  logic [2:0]             alu_op;
  logic                   use_rs1, use_rs2;
  logic [XLEN-1:0]        rf1, rf2;
  logic signed [XLEN-1:0] op_rs1, op_rs2;
  logic                   haz_exe, haz_mem, stall, cond, take, bubble;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // ---- IF/ID register
  always_ff @(posedge clk) begin
    if (reset)       valid_D <= 1'b0;
    else if (!stall) valid_D <= bus.valid_F & ~take;
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      PCmas4_D <= bus.PCmas4_F;
      instr_D  <= bus.instr_F;
    end
  end

  // ---- Decode
  assign opcode = instr_D[6:0];
  assign rd_a   = instr_D[11:7];
  assign funct3 = instr_D[14:12];
  assign rs1_a  = instr_D[19:15];
  assign rs2_a  = instr_D[24:20];
  assign f7b5   = instr_D[30];
  assign imm_i  = {{(XLEN-12){instr_D[31]}}, instr_D[31:20]};
  assign imm_s  = {{(XLEN-12){instr_D[31]}}, instr_D[31:25], instr_D[11:7]};
  assign imm_b  = {{(XLEN-13){instr_D[31]}}, instr_D[31], instr_D[7],
                   instr_D[30:25], instr_D[11:8], 1'b0};

  always_comb begin
    is_r = 1'b0; is_i = 1'b0; is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0;
    legal   = 1'b0;
    alu_op  = ALU_ADD;
    imm_sel = '0;
    case (opcode)
      OP_R: begin
        is_r   = 1'b1;
        legal  = (funct3 != 3'b011) && !(funct3 == 3'b101 && f7b5);
        alu_op = (funct3 == 3'b000 && f7b5) ? ALU_SUB : alu_of_funct3(funct3);
      end
      OP_I: begin
        is_i    = 1'b1;
        legal   = (funct3 != 3'b011) && !(funct3 == 3'b101 && f7b5);
        alu_op  = alu_of_funct3(funct3);
        imm_sel = imm_i;
      end
      OP_LOAD: begin
        is_load = 1'b1;
        legal   = (funct3 == 3'b010);
        imm_sel = imm_i;
      end
      OP_STORE: begin
        is_store = 1'b1;
        legal    = (funct3 == 3'b010);
        imm_sel  = imm_s;
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
        alu_op    = ALU_SUB;
        imm_sel   = imm_b;
      end
      default: ;
    endcase
  end

  assign use_rs1 = is_r | is_i | is_load | is_store | is_branch;
  assign use_rs2 = is_r | is_store | is_branch;

  // Same-cycle writeback is visible to the reader; x0 is hardwired.
  always_comb begin
    rf1 = regs[rs1_a[AW-1:0]];
    if (rs1_a == 5'd0) rf1 = '0;
    else if (bus.reg_write_signal && bus.write_reg == rs1_a) rf1 = bus.write_data;
    rf2 = regs[rs2_a[AW-1:0]];
    if (rs2_a == 5'd0) rf2 = '0;
    else if (bus.reg_write_signal && bus.write_reg == rs2_a) rf2 = bus.write_data;
  end

  // EXE is younger than MEM, so it wins when both target the source.
  always_comb begin
    op_rs1 = rf1;
    if (rs1_a != 5'd0 && bus.RegWrite_MEM && bus.dir_Rd_MEM == rs1_a) op_rs1 = bus.dato_MEM;
    if (rs1_a != 5'd0 && bus.RegWrite_EXE && bus.dir_Rd_EXE == rs1_a) op_rs1 = bus.dato_EXE;
    op_rs2 = rf2;
    if (rs2_a != 5'd0 && bus.RegWrite_MEM && bus.dir_Rd_MEM == rs2_a) op_rs2 = bus.dato_MEM;
    if (rs2_a != 5'd0 && bus.RegWrite_EXE && bus.dir_Rd_EXE == rs2_a) op_rs2 = bus.dato_EXE;
  end

  assign haz_exe = bus.MemRead_EXE && bus.dir_Rd_EXE != 5'd0 &&
                   ((use_rs1 && bus.dir_Rd_EXE == rs1_a) || (use_rs2 && bus.dir_Rd_EXE == rs2_a));
  assign haz_mem = is_branch && bus.MemRead_MEM && bus.dir_Rd_MEM != 5'd0 &&
                   ((use_rs1 && bus.dir_Rd_MEM == rs1_a) || (use_rs2 && bus.dir_Rd_MEM == rs2_a));
  assign stall   = valid_D & (haz_exe | haz_mem);

  always_comb begin
    case (funct3)
      3'b000:  cond = (op_rs1 == op_rs2);
      3'b001:  cond = (op_rs1 != op_rs2);
      3'b100:  cond = (op_rs1 < op_rs2);
      3'b101:  cond = (op_rs1 >= op_rs2);
      3'b110:  cond = ($unsigned(op_rs1) < $unsigned(op_rs2));
      3'b111:  cond = ($unsigned(op_rs1) >= $unsigned(op_rs2));
      default: cond = 1'b0;
    endcase
  end

  assign take   = valid_D & is_branch & cond & ~stall;
  assign bubble = stall | ~valid_D | ~legal;

  assign bus.stall_F     = stall;
  assign bus.Select_PC   = take;
  assign bus.dir_salto   = PCmas4_D - XLEN'(4) + imm_b;
  assign bus.stall_count = stall_cnt;

  // ---- ID/EX register
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      bus.valid_E      <= 1'b0;
      bus.RegWrite_E   <= 1'b0;
      bus.ALUSrc_E     <= 1'b0;
      bus.MemRead_E    <= 1'b0;
      bus.MemWrite_E   <= 1'b0;
      bus.ALUControl_E <= '0;
      bus.Rs1_E        <= '0;
      bus.Rs2_E        <= '0;
      bus.imm_E        <= '0;
      bus.rd_E         <= '0;
      bus.illegal_E    <= !reset && valid_D && !legal && !stall;
    end else begin
      bus.valid_E      <= 1'b1;
      bus.RegWrite_E   <= is_r | is_i | is_load;
      bus.ALUSrc_E     <= is_i | is_load | is_store;
      bus.MemRead_E    <= is_load;
      bus.MemWrite_E   <= is_store;
      bus.ALUControl_E <= alu_op;
      bus.Rs1_E        <= op_rs1;
      bus.Rs2_E        <= op_rs2;
      bus.imm_E        <= imm_sel;
      bus.rd_E         <= (is_r | is_i | is_load) ? rd_a : 5'd0;
      bus.illegal_E    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      stall_cnt <= '0;
    else if (stall) stall_cnt <= sat_inc(stall_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.reg_write_signal && bus.write_reg != 5'd0) begin
      regs[bus.write_reg[AW-1:0]] <= bus.write_data;
    end
  end
endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe with a per-cycle reference model of the
// decode stage and literal expectations for the key scenarios.
module tb_decode_pipe;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int SCW  = 3;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;

  logic clk = 1'b0;
  logic reset;
  logic chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  decode_pipe_if #(.XLEN(XLEN), .STALL_CNT_W(SCW)) bus ();
  decode_pipe #(.XLEN(XLEN), .NREG(NREG), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic v, rw, asrc, mr, mw, ill;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic [31:0] a, b, imm;
  } idex_t;

  logic        m_vD;
  logic [31:0] m_pc, m_ins;
  logic [31:0] m_rf [32];
  logic [2:0]  m_cnt;
  idex_t       m_E;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // kind: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 unknown opcode
  function automatic void classify(input logic [31:0] ins, output int kind, output logic ok,
                                   output logic [2:0] alu, output logic [31:0] imm);
    logic [2:0] f3;
    logic [2:0] f3map [8];
    f3map = '{3'b000, 3'b110, 3'b101, 3'b000, 3'b100, 3'b111, 3'b011, 3'b010};
    f3 = ins[14:12];
    case (ins[6:0])
      7'b0110011: kind = 0;
      7'b0010011: kind = 1;
      7'b0000011: kind = 2;
      7'b0100011: kind = 3;
      7'b1100011: kind = 4;
      default:    kind = 5;
    endcase
    ok = 1'b0; alu = 3'b000; imm = 32'd0;
    if (kind <= 1) begin
      ok  = !(f3 == 3'd3 || (f3 == 3'd5 && ins[30]));
      alu = f3map[f3];
      if (kind == 0 && f3 == 3'd0 && ins[30]) alu = 3'b001;
    end else if (kind == 2 || kind == 3) begin
      ok = (f3 == 3'd2);
    end else if (kind == 4) begin
      ok  = !(f3 == 3'd2 || f3 == 3'd3);
      alu = 3'b001;
    end
    if (kind == 1 || kind == 2) imm = {{20{ins[31]}}, ins[31:20]};
    if (kind == 3) imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    if (kind == 4) imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (bus.RegWrite_EXE && bus.dir_Rd_EXE == rs) return bus.dato_EXE;
    if (bus.RegWrite_MEM && bus.dir_Rd_MEM == rs) return bus.dato_MEM;
    if (bus.reg_write_signal && bus.write_reg == rs) return bus.write_data;
    return m_rf[rs];
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void predict(output logic stall, output logic sel, output logic [31:0] tgt,
                                  output idex_t nxt);
    int kind; logic ok; logic [2:0] alu; logic [31:0] imm, a, b;
    logic [4:0] r1, r2; logic u1, u2, hz;
    classify(m_ins, kind, ok, alu, imm);
    r1 = m_ins[19:15];
    r2 = m_ins[24:20];
    a  = opnd(r1);
    b  = opnd(r2);
    u1 = (kind < 5);
    u2 = (kind == 0 || kind == 3 || kind == 4);
    hz = bus.MemRead_EXE && bus.dir_Rd_EXE != 0 &&
         ((u1 && bus.dir_Rd_EXE == r1) || (u2 && bus.dir_Rd_EXE == r2));
    hz = hz || (kind == 4 && bus.MemRead_MEM && bus.dir_Rd_MEM != 0 &&
         ((u1 && bus.dir_Rd_MEM == r1) || (u2 && bus.dir_Rd_MEM == r2)));
    stall = m_vD && hz;
    sel   = m_vD && kind == 4 && taken(m_ins[14:12], a, b) && !stall;
    tgt   = m_pc - 32'd4 + imm;
    nxt   = '0;
    if (m_vD && !stall && ok) begin
      nxt.v    = 1'b1;
      nxt.rw   = (kind <= 2);
      nxt.asrc = (kind >= 1 && kind <= 3);
      nxt.mr   = (kind == 2);
      nxt.mw   = (kind == 3);
      nxt.alu  = alu;
      nxt.rd   = nxt.rw ? m_ins[11:7] : 5'd0;
      nxt.a    = a;
      nxt.b    = b;
      nxt.imm  = imm;
    end else begin
      nxt.ill  = m_vD && !ok && !stall;
    end
  endfunction

  always @(posedge clk) begin
    logic st, se; logic [31:0] tg; idex_t nx;
    if (reset) begin
      m_vD  = 1'b0;
      m_E   = '0;
      m_cnt = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      predict(st, se, tg, nx);
      m_E = nx;
      if (st && m_cnt != 3'(2**SCW - 1)) m_cnt = m_cnt + 3'd1;
      if (bus.reg_write_signal && bus.write_reg != 0) m_rf[bus.write_reg] = bus.write_data;
      if (!st) begin
        m_vD  = bus.valid_F && !se;
        m_pc  = bus.PCmas4_F;
        m_ins = bus.instr_F;
      end
    end
  end

  always @(negedge clk) begin
    logic st, se; logic [31:0] tg; idex_t nx;
    if (chk_en) begin
      predict(st, se, tg, nx);
      chk("m_stall_F", bus.stall_F, st);
      chk("m_Select_PC", bus.Select_PC, se);
      if (se) chk("m_dir_salto", bus.dir_salto, tg);
      chk("m_idex_ctl", {bus.valid_E, bus.RegWrite_E, bus.ALUSrc_E, bus.MemRead_E, bus.MemWrite_E,
                         bus.illegal_E, bus.ALUControl_E, bus.rd_E},
                        {m_E.v, m_E.rw, m_E.asrc, m_E.mr, m_E.mw, m_E.ill, m_E.alu, m_E.rd});
      chk("m_Rs1_E", bus.Rs1_E, m_E.a);
      chk("m_Rs2_E", bus.Rs2_E, m_E.b);
      chk("m_imm_E", bus.imm_E, m_E.imm);
      chk("m_stall_count", bus.stall_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_F = 0; bus.PCmas4_F = 0; bus.instr_F = 0;
    bus.reg_write_signal = 0; bus.write_reg = 0; bus.write_data = 0;
    bus.dato_EXE = 0; bus.dato_MEM = 0; bus.dir_Rd_EXE = 0; bus.dir_Rd_MEM = 0;
    bus.RegWrite_EXE = 0; bus.RegWrite_MEM = 0; bus.MemRead_EXE = 0; bus.MemRead_MEM = 0;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc4);
    bus.valid_F = 1; bus.instr_F = ins; bus.PCmas4_F = pc4;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.reg_write_signal = 1; bus.write_reg = r; bus.write_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vec [12];
    idle();
    reset = 1;
    tick();
    chk_en = 1;
    tick();
    chk("rst_valid_E", bus.valid_E, 0);
    chk("rst_stall_count", bus.stall_count, 0);
    chk("rst_stall_F", bus.stall_F, 0);
    reset = 0;

    wb(6, 77); tick();
    wb(7, 32'hFFFF_FFFF); tick();
    wb(8, 1); tick();
    wb(0, 123); tick();
    bus.reg_write_signal = 0;

    // addi x1,x0,5 ; add x2,x1,x1 with x1 forwarded from EXE
    fetch(enc_i(12'd5, 0, 3'd0, 1, OPI), 32'h104); tick();
    fetch(enc_r(7'd0, 1, 1, 3'd0, 2), 32'h108); tick();
    chk("addi_valid_E", bus.valid_E, 1);
    chk("addi_imm_E", bus.imm_E, 5);
    chk("addi_ALUSrc_E", bus.ALUSrc_E, 1);
    chk("addi_rd_E", bus.rd_E, 1);
    bus.valid_F = 0; bus.RegWrite_EXE = 1; bus.dir_Rd_EXE = 1; bus.dato_EXE = 5;
    #1 chk("fwd_no_stall", bus.stall_F, 0);
    tick();
    chk("fwd_Rs1_E", bus.Rs1_E, 5);
    chk("fwd_Rs2_E", bus.Rs2_E, 5);
    chk("add_ALUSrc_E", bus.ALUSrc_E, 0);
    chk("add_ALUControl_E", bus.ALUControl_E, 3'b000);
    idle();

    // lw x3 in EXE, add x4,x3,x0 in ID
    fetch(enc_r(7'd0, 0, 3, 3'd0, 4), 32'h10C); tick();
    fetch(enc_r(7'd0, 2, 1, 3'd4, 12), 32'h110);
    bus.MemRead_EXE = 1; bus.RegWrite_EXE = 1; bus.dir_Rd_EXE = 3;
    #1 chk("lu_stall_F", bus.stall_F, 1);
    tick();
    chk("lu_bubble_valid_E", bus.valid_E, 0);
    chk("lu_stall_count", bus.stall_count, 1);
    bus.MemRead_EXE = 0; bus.RegWrite_EXE = 0; bus.dir_Rd_EXE = 0;
    bus.MemRead_MEM = 1; bus.RegWrite_MEM = 1; bus.dir_Rd_MEM = 3; bus.dato_MEM = 42;
    #1 chk("lu_release", bus.stall_F, 0);
    tick();
    chk("lu_valid_E", bus.valid_E, 1);
    chk("lu_Rs1_E", bus.Rs1_E, 42);
    chk("lu_rd_E", bus.rd_E, 4);
    idle(); tick();

    // beq x5,x6,+16 with x5 loaded in MEM, then resolved from WB
    fetch(enc_b(13'd16, 6, 5, 3'd0), 32'h204); tick();
    fetch(enc_i(12'd1, 0, 3'd0, 20, OPI), 32'h208);
    bus.MemRead_MEM = 1; bus.RegWrite_MEM = 1; bus.dir_Rd_MEM = 5; bus.dato_MEM = 0;
    #1 chk("br_stall_F", bus.stall_F, 1);
    chk("br_no_take_stalled", bus.Select_PC, 0);
    tick();
    chk("br_stall_count", bus.stall_count, 2);
    bus.MemRead_MEM = 0; bus.RegWrite_MEM = 0; bus.dir_Rd_MEM = 0;
    wb(5, 77);
    #1 chk("beq_release", bus.stall_F, 0);
    chk("beq_Select_PC", bus.Select_PC, 1);
    chk("beq_dir_salto", bus.dir_salto, 32'h210);
    tick();
    chk("beq_valid_E", bus.valid_E, 1);
    chk("beq_ctl", {bus.RegWrite_E, bus.MemRead_E, bus.MemWrite_E}, 3'b000);
    chk("beq_Rs1_E", bus.Rs1_E, 77);
    chk("beq_ALUControl_E", bus.ALUControl_E, 3'b001);
    idle(); tick();
    chk("beq_squash", bus.valid_E, 0);

    // blt / bltu on -1 vs 1
    fetch(enc_b(13'h1FF8, 8, 7, 3'd4), 32'h304); tick();
    bus.valid_F = 0;
    #1 chk("blt_taken", bus.Select_PC, 1);
    chk("blt_dir_salto", bus.dir_salto, 32'h2F8);
    tick();
    fetch(enc_b(13'h1FF8, 8, 7, 3'd6), 32'h30C); tick();
    bus.valid_F = 0;
    #1 chk("bltu_not_taken", bus.Select_PC, 0);
    tick();

    // unknown opcode is dropped with a one-cycle illegal flag
    fetch(32'h0000_007F, 32'h404); tick();
    bus.valid_F = 0; tick();
    chk("ill_illegal_E", bus.illegal_E, 1);
    chk("ill_valid_E", bus.valid_E, 0);
    tick();
    chk("ill_one_cycle", bus.illegal_E, 0);

    // x0 stays zero, even against a same-cycle write to x0
    fetch(enc_r(7'd0, 0, 0, 3'd0, 10), 32'h504); tick();
    bus.valid_F = 0; wb(0, 99); tick();
    chk("x0_valid_E", bus.valid_E, 1);
    chk("x0_Rs1_E", bus.Rs1_E, 0);
    chk("x0_Rs2_E", bus.Rs2_E, 0);
    idle();

    // mixed stream checked by the model
    vec[0]  = enc_s(12'hFFC, 6, 1, 3'd2);
    vec[1]  = enc_i(12'd8, 2, 3'd2, 9, OPL);
    vec[2]  = enc_i(12'd8, 2, 3'd0, 9, OPL);
    vec[3]  = enc_r(7'h20, 7, 8, 3'd0, 13);
    vec[4]  = enc_r(7'h20, 2, 1, 3'd5, 14);
    vec[5]  = enc_r(7'h00, 2, 1, 3'd5, 14);
    vec[6]  = enc_r(7'h00, 8, 7, 3'd2, 15);
    vec[7]  = enc_i(12'h0F0, 7, 3'd7, 16, OPI);
    vec[8]  = enc_i(12'h800, 8, 3'd2, 17, OPI);
    vec[9]  = enc_b(13'd40, 8, 7, 3'd1);
    vec[10] = enc_r(7'h00, 1, 1, 3'd3, 18);
    vec[11] = enc_b(13'h1FF0, 8, 7, 3'd7);
    for (int k = 0; k < 12; k++) begin
      fetch(vec[k], 32'h700 + 32'(4 * k));
      bus.RegWrite_MEM = k[0]; bus.dir_Rd_MEM = 7; bus.dato_MEM = 32'(k * 3);
      tick();
    end
    idle(); tick(); tick();

    // long load-use stall saturates the counter, then reset wins mid-stall
    fetch(enc_r(7'd0, 0, 3, 3'd0, 4), 32'h604); tick();
    bus.valid_F = 0; bus.MemRead_EXE = 1; bus.dir_Rd_EXE = 3;
    repeat (9) tick();
    chk("sat_stall_count", bus.stall_count, 7);
    chk("sat_stall_F", bus.stall_F, 1);
    reset = 1; tick();
    reset = 0;
    #1 chk("rst_mid_stall_F", bus.stall_F, 0);
    chk("rst_mid_Select_PC", bus.Select_PC, 0);
    chk("rst_mid_ctl", {bus.valid_E, bus.RegWrite_E, bus.ALUSrc_E, bus.MemRead_E, bus.MemWrite_E,
                        bus.illegal_E, bus.ALUControl_E, bus.rd_E}, 0);
    chk("rst_mid_data", bus.Rs1_E | bus.Rs2_E | bus.imm_E, 0);
    chk("rst_mid_count", bus.stall_count, 0);
    tick();
    chk("rst_after_stall_F", bus.stall_F, 0);
    idle();

    // register file was cleared by reset
    fetch(enc_r(7'd0, 6, 5, 3'd0, 11), 32'h804); tick();
    bus.valid_F = 0; tick();
    chk("rf_cleared_Rs1", bus.Rs1_E, 0);
    chk("rf_cleared_Rs2", bus.Rs2_E, 0);
    tick();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
